// File: rtl/dct_coeff_accum.sv
`default_nettype none
// ============================================================================
// Module      : dct_coeff_accum
// Description : Streams one 8x8 pixel block in raster order and accumulates
//               the level-shifted pixels against an external cosine LUT for a
//               single (k1,k2) basis. The scaled, saturated coefficient is
//               handed to the quantiser over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_coeff_accum #(
    parameter int PIX_W     = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 10,
    parameter int OUT_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic [2:0]       n1,
    output logic [2:0]       n2,
    input  logic [31:0]      cos_term,
    output logic [OUT_W-1:0] coeff_data,
    output logic             coeff_valid,
    input  logic             coeff_ready
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Level shift of 2^(PIX_W-1), held in the signed PIX_W+1 domain.
    localparam logic signed [PIX_W:0] c_level = {2'b01, {(PIX_W-1){1'b0}}};

    // Output saturation limits expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] c_sat_max =
        ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] c_sat_min = ~c_sat_max;

    localparam logic [5:0] c_last_pixel = 6'd63;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    state_q,       state_d;
    logic [5:0]                count_q,       count_d;
    logic signed [ACC_W-1:0]   acc_q,         acc_d;
    logic [OUT_W-1:0]          coeff_data_q,  coeff_data_d;
    logic                      coeff_valid_q, coeff_valid_d;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic                      w_accept;
    logic signed [PIX_W:0]     w_pix_s;
    logic signed [ACC_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [OUT_W-1:0]          w_coeff_sat;

    // Ready is decoded from the registered state, so it only re-asserts the
    // cycle after the output handshake moves the FSM back to IDLE.
    assign pixel_ready = (state_q != S_DONE);
    assign w_accept    = pixel_valid & pixel_ready;

    // The LUT indices track the pixel currently presented on the input.
    assign n1 = count_q[5:3];
    assign n2 = count_q[2:0];

    assign coeff_data  = coeff_data_q;
    assign coeff_valid = coeff_valid_q;

    // Level shift into signed range.
    assign w_pix_s = $signed({1'b0, pixel_data}) - c_level;

    // The product is kept modulo 2^ACC_W: the low ACC_W bits of a product
    // depend only on the low ACC_W bits of the sign-extended operands, so
    // this equals the full-width product truncated to the accumulator.
    assign w_prod = $signed(ACC_W'(w_pix_s)) * $signed(ACC_W'($signed(cos_term)));

    // Running sum including the pixel presented this cycle; no saturation
    // is needed inside the block since 64*128*256 fits easily.
    assign w_sum = acc_q + w_prod;

    // Arithmetic shift floors toward -inf, removing the LUT scale and the
    // 1/4 DCT normalisation in one step.
    assign w_shifted = w_sum >>> OUT_SHIFT;

    // Clamp the scaled sum to the signed output range.
    always_comb begin
        w_coeff_sat = w_shifted[OUT_W-1:0];
        if (w_shifted > c_sat_max) begin
            w_coeff_sat = c_sat_max[OUT_W-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_coeff_sat = c_sat_min[OUT_W-1:0];
        end
    end

    // Next-state and datapath update; every register holds unless an
    // accepted pixel or an output handshake moves it.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        acc_d         = acc_q;
        coeff_data_d  = coeff_data_q;
        coeff_valid_d = coeff_valid_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    acc_d   = w_prod;
                    count_d = 6'd1;
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (w_accept) begin
                    acc_d = w_sum;
                    if (count_q == c_last_pixel) begin
                        coeff_data_d  = w_coeff_sat;
                        coeff_valid_d = 1'b1;
                        count_d       = 6'd0;
                        state_d       = S_DONE;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
            end

            S_DONE: begin
                // Coefficient is held stable until the quantiser takes it;
                // coeff_data keeps its last value after the handshake.
                if (coeff_ready) begin
                    coeff_valid_d = 1'b0;
                    acc_d         = '0;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d       = S_IDLE;
                count_d       = 6'd0;
                acc_d         = '0;
                coeff_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= 6'd0;
            acc_q         <= '0;
            coeff_data_q  <= '0;
            coeff_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            coeff_data_q  <= coeff_data_d;
            coeff_valid_q <= coeff_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_coeff_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_coeff_accum
// Description : Directed self-checking bench for dct_coeff_accum. Two
//               instances (OUT_W=12 and OUT_W=10) share the same stimulus,
//               each paired with its own (k1=1,k2=4) cosine LUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_coeff_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        coeff_ready;

    logic        pr0, cv0, pr1, cv1;
    logic [2:0]  n1_0, n2_0, n1_1, n2_1;
    logic [31:0] cos0, cos1;
    logic [11:0] cd0;
    logic [9:0]  cd1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // (k1=1,k2=4) cosine table, scale 256.
    function automatic logic [31:0] lut(input logic [2:0] r, input logic [2:0] c);
        int m;
        int v;
        case (r)
            3'd0, 3'd7: m = 177;
            3'd1, 3'd6: m = 150;
            3'd2, 3'd5: m = 100;
            default:    m = 35;
        endcase
        v = (c == 3'd0 || c == 3'd3 || c == 3'd4 || c == 3'd7) ? m : -m;
        if (r >= 3'd4) v = -v;
        return 32'(v);
    endfunction

    // Pixel pattern per mode, chosen from the LUT sign at raster index i.
    function automatic logic [7:0] pix(input int mode, input int i);
        logic [31:0] c;
        bit          pos;
        c   = lut(3'(i >> 3), 3'(i & 7));
        pos = ($signed(c) > 0);
        case (mode)
            0:       return 8'd128;
            1:       return pos ? 8'd228 : 8'd28;
            2:       return pos ? 8'd255 : 8'd0;
            3:       return pos ? 8'd0   : 8'd255;
            default: return pos ? 8'd28  : 8'd228;
        endcase
    endfunction

    assign cos0 = lut(n1_0, n2_0);
    assign cos1 = lut(n1_1, n2_1);

    dct_coeff_accum #(.PIX_W(8), .ACC_W(32), .OUT_SHIFT(10), .OUT_W(12)) u_dut0 (
        .clk(clk), .reset(reset),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pr0),
        .n1(n1_0), .n2(n2_0), .cos_term(cos0),
        .coeff_data(cd0), .coeff_valid(cv0), .coeff_ready(coeff_ready)
    );

    dct_coeff_accum #(.PIX_W(8), .ACC_W(32), .OUT_SHIFT(10), .OUT_W(10)) u_dut1 (
        .clk(clk), .reset(reset),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pr1),
        .n1(n1_1), .n2(n2_1), .cos_term(cos1),
        .coeff_data(cd1), .coeff_valid(cv1), .coeff_ready(coeff_ready)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one 64-pixel block; counts index/ready deviations from the
    // expected raster position into idx_bad for the caller to judge.
    task automatic send_block(input int mode, input bit gaps, input bit hold_valid,
                              output int idx_bad);
        int g;
        idx_bad = 0;
        for (int i = 0; i < 64; i++) begin
            logic [5:0] idx;
            idx = 6'(i);
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                pixel_valid = 1'b0;
                pixel_data  = 8'($urandom);
                cycle();
                if ({n1_0, n2_0} !== idx || {n1_1, n2_1} !== idx) idx_bad++;
            end
            pixel_valid = 1'b1;
            pixel_data  = pix(mode, i);
            if ({n1_0, n2_0} !== idx || {n1_1, n2_1} !== idx || pr0 !== 1'b1) idx_bad++;
            cycle();
        end
        pixel_valid = hold_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; pixel_valid = 1'b1; pixel_data = 8'd200; coeff_ready = 1'b0;
        repeat (3) cycle();
        reset = 1'b0; pixel_valid = 1'b0;
        n_checks++; if (pr0 !== 1'b1 || pr1 !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b/%b want 1/1", pr0, pr1); end
        n_checks++; if (cv0 !== 1'b0 || cv1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b/%b want 0/0", cv0, cv1); end
        n_checks++; if (cd0 !== 12'd0 || cd1 !== 10'd0) begin n_errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", cd0, cd1); end
        n_checks++; if ({n1_0, n2_0} !== 6'd0) begin n_errors++; $display("FAIL reset_index: got (%0d,%0d) want (0,0)", n1_0, n2_0); end
    endtask

    task automatic test_zero_block();
        int bad;
        coeff_ready = 1'b1;
        send_block(0, 1'b0, 1'b0, bad);
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL zero_index: got %0d deviations want 0", bad); end
        n_checks++; if (cv0 !== 1'b1 || cv1 !== 1'b1) begin n_errors++; $display("FAIL zero_latency: got valid %b/%b want 1/1", cv0, cv1); end
        n_checks++; if (pr0 !== 1'b0) begin n_errors++; $display("FAIL zero_ready_low: got %b want 0", pr0); end
        n_checks++; if ($signed(cd0) !== 0 || $signed(cd1) !== 0) begin n_errors++; $display("FAIL zero_data: got %0d/%0d want 0/0", $signed(cd0), $signed(cd1)); end
        cycle();
        n_checks++; if (cv0 !== 1'b0 || pr0 !== 1'b1) begin n_errors++; $display("FAIL zero_handshake: got valid %b ready %b want 0 1", cv0, pr0); end
    endtask

    task automatic test_coeff_basic();
        int bad;
        coeff_ready = 1'b1;
        send_block(1, 1'b0, 1'b0, bad);
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL basic_index: got %0d deviations want 0", bad); end
        n_checks++; if (cv0 !== 1'b1 || $signed(cd0) !== 721) begin n_errors++; $display("FAIL basic_721: got valid %b data %0d want 1 721", cv0, $signed(cd0)); end
        n_checks++; if ($signed(cd1) !== 511) begin n_errors++; $display("FAIL basic_sat10: got %0d want 511", $signed(cd1)); end
        cycle();
        n_checks++; if (cv0 !== 1'b0 || pr0 !== 1'b1 || $signed(cd0) !== 721) begin n_errors++; $display("FAIL basic_after_hs: got valid %b ready %b data %0d want 0 1 721", cv0, pr0, $signed(cd0)); end
        send_block(4, 1'b0, 1'b0, bad);
        n_checks++; if ($signed(cd0) !== -722) begin n_errors++; $display("FAIL neg_floor: got %0d want -722", $signed(cd0)); end
        n_checks++; if ($signed(cd1) !== -512) begin n_errors++; $display("FAIL neg_sat10: got %0d want -512", $signed(cd1)); end
        cycle();
    endtask

    task automatic test_saturation();
        int bad;
        coeff_ready = 1'b1;
        send_block(2, 1'b0, 1'b0, bad);
        n_checks++; if ($signed(cd0) !== 920) begin n_errors++; $display("FAIL sat_pos12: got %0d want 920", $signed(cd0)); end
        n_checks++; if ($signed(cd1) !== 511) begin n_errors++; $display("FAIL sat_pos10: got %0d want 511", $signed(cd1)); end
        cycle();
        send_block(3, 1'b0, 1'b0, bad);
        n_checks++; if ($signed(cd0) !== -921) begin n_errors++; $display("FAIL sat_neg12: got %0d want -921", $signed(cd0)); end
        n_checks++; if ($signed(cd1) !== -512) begin n_errors++; $display("FAIL sat_neg10: got %0d want -512", $signed(cd1)); end
        cycle();
    endtask

    task automatic test_gaps();
        int bad;
        coeff_ready = 1'b1;
        send_block(1, 1'b1, 1'b0, bad);
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL gaps_hold: got %0d index deviations want 0", bad); end
        n_checks++; if (cv0 !== 1'b1 || $signed(cd0) !== 721) begin n_errors++; $display("FAIL gaps_721: got valid %b data %0d want 1 721", cv0, $signed(cd0)); end
        cycle();
    endtask

    task automatic test_backpressure();
        int bad;
        coeff_ready = 1'b0;
        send_block(1, 1'b0, 1'b1, bad);
        n_checks++; if (cv0 !== 1'b1 || $signed(cd0) !== 721) begin n_errors++; $display("FAIL bp_first: got valid %b data %0d want 1 721", cv0, $signed(cd0)); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (cv0 !== 1'b1 || pr0 !== 1'b0 || $signed(cd0) !== 721 || {n1_0, n2_0} !== 6'd0) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got valid %b ready %b data %0d idx %0d want 1 0 721 0", k, cv0, pr0, $signed(cd0), {n1_0, n2_0});
            end
        end
        coeff_ready = 1'b1;
        cycle();
        pixel_valid = 1'b0;
        n_checks++; if (cv0 !== 1'b0 || pr0 !== 1'b1 || {n1_0, n2_0} !== 6'd0 || $signed(cd0) !== 721) begin n_errors++; $display("FAIL bp_release: got valid %b ready %b idx %0d data %0d want 0 1 0 721", cv0, pr0, {n1_0, n2_0}, $signed(cd0)); end
        send_block(2, 1'b0, 1'b0, bad);
        n_checks++; if (bad !== 0 || $signed(cd0) !== 920) begin n_errors++; $display("FAIL bp_next_block: got %0d deviations data %0d want 0 920", bad, $signed(cd0)); end
        cycle();
    endtask

    task automatic test_reset_mid_block();
        int bad;
        coeff_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = pix(1, i);
            cycle();
        end
        n_checks++; if ({n1_0, n2_0} !== 6'd30) begin n_errors++; $display("FAIL mid_progress: got idx %0d want 30", {n1_0, n2_0}); end
        reset = 1'b1;
        cycle();
        reset = 1'b0; pixel_valid = 1'b0;
        n_checks++; if ({n1_0, n2_0} !== 6'd0 || pr0 !== 1'b1 || cv0 !== 1'b0) begin n_errors++; $display("FAIL mid_reset: got idx %0d ready %b valid %b want 0 1 0", {n1_0, n2_0}, pr0, cv0); end
        send_block(0, 1'b0, 1'b0, bad);
        n_checks++; if (bad !== 0 || cv0 !== 1'b1 || $signed(cd0) !== 0) begin n_errors++; $display("FAIL mid_block: got %0d deviations valid %b data %0d want 0 1 0", bad, cv0, $signed(cd0)); end
        cycle();
    endtask

    initial begin
        reset = 1'b1; pixel_valid = 1'b0; pixel_data = 8'd0; coeff_ready = 1'b0;
        test_reset();
        test_zero_block();
        test_coeff_basic();
        test_saturation();
        test_gaps();
        test_backpressure();
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
